// File: rtl/axis_counter_pkg.sv
// rtl/axis_counter_pkg.sv - shared types and packet-boundary rule for the counter stream
`timescale 1ns/1ps
package axis_counter_pkg;

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } chk_state_t;

  localparam logic [3:0] TLAST_NIBBLE_MASK = 4'hF;
  localparam logic [3:0] TLAST_NIBBLE_VAL  = 4'h8;

  // A beat closes a packet when the low data nibble carries the marker value.
  function automatic logic nibble_marks_last(input logic [3:0] nib);
    return (nib & TLAST_NIBBLE_MASK) == TLAST_NIBBLE_VAL;
  endfunction

endpackage

// File: rtl/axis_ready_pattern_gen.sv
// rtl/axis_ready_pattern_gen.sv - rotating duty mask producing a registered TREADY
`timescale 1ns/1ps
module axis_ready_pattern_gen #(
  parameter logic [7:0] C_READY_PATTERN = 8'hFF
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tready
);

  logic [7:0] pat;

  // Ready is mask bit 0 registered; the mask rotates right only while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat    <= C_READY_PATTERN;
      tready <= 1'b0;
    end else begin
      tready <= enable & pat[0];
      if (enable) begin
        pat <= {pat[0], pat[7:1]};
      end
    end
  end

endmodule

// File: rtl/axis_counter_checker_s00_axis.sv
// rtl/axis_counter_checker_s00_axis.sv - AXIS sink checking the incrementing counter stream
`timescale 1ns/1ps
module axis_counter_checker_s00_axis
  import axis_counter_pkg::*;
#(
  parameter int         C_S_AXIS_TDATA_WIDTH = 32,
  parameter logic [7:0] C_READY_PATTERN      = 8'hFF,
  parameter int         C_ERR_CNT_WIDTH      = 16
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESET,
  input  logic                                S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,
  input  logic                                chk_enable,
  input  logic                                chk_clear,
  output logic                                locked,
  output logic [31:0]                         beat_count,
  output logic [31:0]                         pkt_count,
  output logic [C_ERR_CNT_WIDTH-1:0]          seq_err_count,
  output logic [C_ERR_CNT_WIDTH-1:0]          last_err_count,
  output logic [C_ERR_CNT_WIDTH-1:0]          strb_err_count,
  output logic                                proto_err
);

  localparam int                         W       = C_S_AXIS_TDATA_WIDTH;
  localparam int                         E       = C_ERR_CNT_WIDTH;
  localparam logic [W-1:0]               DATA_ONE = W'(1);
  localparam logic [E-1:0]               ERR_ONE  = E'(1);
  localparam logic [E-1:0]               ERR_MAX  = '1;

  chk_state_t   state;
  chk_state_t   state_next;
  logic [W-1:0] expected;
  logic [W-1:0] expected_next;
  logic         beat;
  logic         seq_err;
  logic         last_err;
  logic         strb_err;
  logic         cap_valid;
  logic [W-1:0] cap_data;
  logic         cap_last;
  logic         proto_viol;

  axis_ready_pattern_gen #(
    .C_READY_PATTERN (C_READY_PATTERN)
  ) u_ready_gen (
    .clk    (S_AXIS_ACLK),
    .rst    (S_AXIS_ARESET),
    .enable (chk_enable),
    .tready (S_AXIS_TREADY)
  );

  // A clear in the same cycle swallows the beat: it is neither counted nor checked.
  assign beat     = S_AXIS_TVALID & S_AXIS_TREADY & ~chk_clear;
  assign last_err = beat & (S_AXIS_TLAST != nibble_marks_last(S_AXIS_TDATA[3:0]));
  assign strb_err = beat & ~(&S_AXIS_TSTRB);
  assign locked   = (state == TRACK);

  // Sequence tracker state register.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state    <= SYNC;
      expected <= '0;
    end else begin
      state    <= state_next;
      expected <= expected_next;
    end
  end

  // Next expected value always follows the accepted data, so a mismatch resyncs for free.
  always_comb begin
    state_next    = state;
    expected_next = expected;
    seq_err       = 1'b0;
    if (chk_clear) begin
      state_next = SYNC;
    end else if (beat) begin
      expected_next = S_AXIS_TDATA + DATA_ONE;
      case (state)
        SYNC:  state_next = TRACK;
        TRACK: seq_err    = (S_AXIS_TDATA != expected);
      endcase
    end
  end

  // Beat and packet counters wrap; error counters saturate at all ones.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      beat_count     <= '0;
      pkt_count      <= '0;
      seq_err_count  <= '0;
      last_err_count <= '0;
      strb_err_count <= '0;
    end else if (chk_clear) begin
      beat_count     <= '0;
      pkt_count      <= '0;
      seq_err_count  <= '0;
      last_err_count <= '0;
      strb_err_count <= '0;
    end else begin
      if (beat) begin
        beat_count <= beat_count + 32'd1;
      end
      if (beat && S_AXIS_TLAST) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (seq_err && (seq_err_count != ERR_MAX)) begin
        seq_err_count <= seq_err_count + ERR_ONE;
      end
      if (last_err && (last_err_count != ERR_MAX)) begin
        last_err_count <= last_err_count + ERR_ONE;
      end
      if (strb_err && (strb_err_count != ERR_MAX)) begin
        strb_err_count <= strb_err_count + ERR_ONE;
      end
    end
  end

  // A stalled beat must be presented unchanged on the following clock.
  assign proto_viol = cap_valid &
                      (~S_AXIS_TVALID | (S_AXIS_TDATA != cap_data) | (S_AXIS_TLAST != cap_last));

  // Stall capture and sticky stability flag.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_last  <= 1'b0;
      proto_err <= 1'b0;
    end else if (chk_clear) begin
      cap_valid <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (proto_viol) begin
        proto_err <= 1'b1;
      end
      cap_valid <= S_AXIS_TVALID & ~S_AXIS_TREADY;
      cap_data  <= S_AXIS_TDATA;
      cap_last  <= S_AXIS_TLAST;
    end
  end

endmodule
